// File: rtl/traffic_light_controller.sv
// ---------------------------------------------------------------------------
// traffic_light_controller
//
// Phase sequencer for the red/green light. It steps the light through
// GREEN -> YELLOW -> RED -> GREEN with a fixed length per phase and counts
// down the ticks left in the current phase. One clock edge is one second.
// A pedestrian request cuts a long GREEN short. An optional night blink
// mode flashes YELLOW.
//
// Optional feature macro: NIGHT_MODE_EN
//   defined   : builds the BLINK phase, which is driven by night_mode
//   undefined : night_mode is ignored and state never shows NONE
//
// Parameters:
//   GREEN_TIME    - GREEN length in ticks (1..99)
//   YELLOW_TIME   - YELLOW length in ticks (1..99)
//   RED_TIME      - RED length in ticks (1..99)
//   PED_MIN_GREEN - GREEN remaining-time cap on a pedestrian request
//
// Ports:
//   clk_div_1hz - the only clock, one tick per second
//   rst         - synchronous active-high reset
//   ped_req     - pedestrian button, level-sampled on every edge
//   night_mode  - night blink request (only used with NIGHT_MODE_EN)
//   state       - RED=00, YELLOW=01, GREEN=10, NONE=11 (registered)
//   count_tens  - BCD tens digit of the remaining ticks (registered)
//   count_ones  - BCD ones digit of the remaining ticks (registered)
//   ped_ack     - one-cycle pulse when a request shortens GREEN (registered)
// ---------------------------------------------------------------------------
module traffic_light_controller #(
    parameter int GREEN_TIME    = 10,
    parameter int YELLOW_TIME   = 3,
    parameter int RED_TIME      = 15,
    parameter int PED_MIN_GREEN = 5
) (
    input  logic       clk_div_1hz,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [1:0] state,
    output logic [3:0] count_tens,
    output logic [3:0] count_ones,
    output logic       ped_ack
);

    typedef enum logic [1:0] {
        PH_RED,
        PH_YELLOW,
        PH_GREEN
`ifdef NIGHT_MODE_EN
        , PH_BLINK
`endif
    } phase_t;

    localparam logic [6:0] LP_GREEN   = 7'(GREEN_TIME);
    localparam logic [6:0] LP_YELLOW  = 7'(YELLOW_TIME);
    localparam logic [6:0] LP_RED     = 7'(RED_TIME);
    localparam logic [6:0] LP_PED_MIN = 7'(PED_MIN_GREEN);

    phase_t     r_phase;
    logic [6:0] r_remaining;
    logic       r_pedPending;

    phase_t     w_phaseNext;
    logic [6:0] w_remNext;
    logic       w_pendNext;
    logic       w_ackNext;
    logic [1:0] w_stateNext;

`ifdef NIGHT_MODE_EN
    // blink_phase: 0 shows YELLOW, 1 shows NONE
    logic r_blinkPhase;
    logic w_blinkNext;
`else
    logic w_unusedNight;
    assign w_unusedNight = night_mode;
`endif

    // Next-state logic. Night entry and exit take priority over the normal
    // phase sequence. Inside a phase, the phase-end reload beats a
    // pedestrian truncation.
    always_comb begin
        w_phaseNext = r_phase;
        w_remNext   = r_remaining;
        w_pendNext  = r_pedPending;
        w_ackNext   = 1'b0;
`ifdef NIGHT_MODE_EN
        w_blinkNext = r_blinkPhase;
        if (r_phase == PH_BLINK) begin
            if (night_mode) begin
                w_blinkNext = ~r_blinkPhase;
            end else begin
                w_phaseNext = PH_RED;
                w_remNext   = LP_RED;
                w_blinkNext = 1'b0;
            end
        end else if (night_mode) begin
            w_phaseNext = PH_BLINK;
            w_remNext   = 7'd0;
            w_pendNext  = 1'b0;
            w_blinkNext = 1'b0;
        end else
`endif
        begin
            case (r_phase)
                PH_GREEN: begin
                    // A request that cannot shorten GREEN is dropped rather
                    // than held over, so pending always clears here.
                    w_pendNext = 1'b0;
                    if (r_remaining == 7'd1) begin
                        w_phaseNext = PH_YELLOW;
                        w_remNext   = LP_YELLOW;
                    end else if ((ped_req || r_pedPending) &&
                                 (r_remaining > LP_PED_MIN)) begin
                        w_remNext = LP_PED_MIN;
                        w_ackNext = 1'b1;
                    end else begin
                        w_remNext = r_remaining - 7'd1;
                    end
                end
                PH_YELLOW: begin
                    if (ped_req) w_pendNext = 1'b1;
                    if (r_remaining == 7'd1) begin
                        w_phaseNext = PH_RED;
                        w_remNext   = LP_RED;
                    end else begin
                        w_remNext = r_remaining - 7'd1;
                    end
                end
                PH_RED: begin
                    if (ped_req) w_pendNext = 1'b1;
                    if (r_remaining == 7'd1) begin
                        w_phaseNext = PH_GREEN;
                        w_remNext   = LP_GREEN;
                    end else begin
                        w_remNext = r_remaining - 7'd1;
                    end
                end
                default: begin
                    w_phaseNext = PH_RED;
                    w_remNext   = LP_RED;
                    w_pendNext  = 1'b0;
                end
            endcase
        end
    end

    // Light encoding is computed from the next phase so the registered
    // state and the registered count always change on the same edge.
    always_comb begin
        w_stateNext = 2'b00;
        case (w_phaseNext)
            PH_RED:    w_stateNext = 2'b00;
            PH_YELLOW: w_stateNext = 2'b01;
            PH_GREEN:  w_stateNext = 2'b10;
`ifdef NIGHT_MODE_EN
            PH_BLINK:  w_stateNext = w_blinkNext ? 2'b11 : 2'b01;
`endif
            default:   w_stateNext = 2'b00;
        endcase
    end

    // State and output registers; reset returns to the start of RED.
    always_ff @(posedge clk_div_1hz) begin
        if (rst) begin
            r_phase      <= PH_RED;
            r_remaining  <= LP_RED;
            r_pedPending <= 1'b0;
            ped_ack      <= 1'b0;
            state        <= 2'b00;
            count_tens   <= 4'(RED_TIME / 10);
            count_ones   <= 4'(RED_TIME % 10);
`ifdef NIGHT_MODE_EN
            r_blinkPhase <= 1'b0;
`endif
        end else begin
            r_phase      <= w_phaseNext;
            r_remaining  <= w_remNext;
            r_pedPending <= w_pendNext;
            ped_ack      <= w_ackNext;
            state        <= w_stateNext;
            count_tens   <= 4'(w_remNext / 7'd10);
            count_ones   <= 4'(w_remNext % 7'd10);
`ifdef NIGHT_MODE_EN
            r_blinkPhase <= w_blinkNext;
`endif
        end
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_controller
//
// Directed bench for traffic_light_controller with default parameters.
// Walks full phase cycles, pedestrian truncation in GREEN, a request held
// over from RED, dropped requests near the end of GREEN, and reset
// mid-YELLOW. It also walks the night blink sequence when NIGHT_MODE_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_traffic_light_controller;

    localparam logic [1:0] ST_RED    = 2'b00;
    localparam logic [1:0] ST_YELLOW = 2'b01;
    localparam logic [1:0] ST_GREEN  = 2'b10;
`ifdef NIGHT_MODE_EN
    localparam logic [1:0] ST_NONE   = 2'b11;
`endif

    logic       clock;
    logic       rst;
    logic       pedReq;
    logic       nightMode;
    logic [1:0] state;
    logic [3:0] countTens;
    logic [3:0] countOnes;
    logic       pedAck;

    int vectors     = 0;
    int miscompares = 0;

    traffic_light_controller dut (
        .clk_div_1hz(clock),
        .rst        (rst),
        .ped_req    (pedReq),
        .night_mode (nightMode),
        .state      (state),
        .count_tens (countTens),
        .count_ones (countOnes),
        .ped_ack    (pedAck)
    );

    // 10-unit clock period; outputs are sampled 1 unit after each rising edge.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive the inputs for the next edge, then wait until just past it.
    task automatic applyStimulus(input logic r, input logic p, input logic n);
        rst       = r;
        pedReq    = p;
        nightMode = n;
        @(posedge clock);
        #1;
    endtask

    // Compare every output against hand-derived values.
    task automatic checkOutput(input string tag, input logic [1:0] expState,
                               input logic [3:0] expTens,
                               input logic [3:0] expOnes,
                               input logic expAck);
        vectors++;
        assert (state === expState) else begin
            miscompares++;
            $error("FAIL %s state got %b expected %b", tag, state, expState);
        end
        vectors++;
        assert (countTens === expTens) else begin
            miscompares++;
            $error("FAIL %s tens got %0d expected %0d", tag, countTens, expTens);
        end
        vectors++;
        assert (countOnes === expOnes) else begin
            miscompares++;
            $error("FAIL %s ones got %0d expected %0d", tag, countOnes, expOnes);
        end
        vectors++;
        assert (pedAck === expAck) else begin
            miscompares++;
            $error("FAIL %s ack got %b expected %b", tag, pedAck, expAck);
        end
    endtask

    // Idle ticks expecting a countdown from 'from' to 'downTo' in one phase.
    task automatic countDown(input string tag, input logic [1:0] expState,
                             input int from, input int downTo);
        for (int k = from; k >= downTo; k--) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput(tag, expState, 4'(k / 10), 4'(k % 10), 1'b0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        pedReq    = 1'b0;
        nightMode = 1'b0;

        // Reset state: RED showing 15.
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("reset", ST_RED, 4'd1, 4'd5, 1'b0);

        // One full cycle with default timings.
        countDown("cycleRed", ST_RED, 14, 1);
        countDown("cycleGreen", ST_GREEN, 10, 1);
        countDown("cycleYellow", ST_YELLOW, 3, 1);
        countDown("cycleRed2", ST_RED, 15, 1);

        // Pedestrian request at GREEN 9 truncates to 5 with a single ack.
        countDown("pedGreen", ST_GREEN, 10, 9);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pedTrunc", ST_GREEN, 4'd0, 4'd5, 1'b1);
        countDown("pedAfter", ST_GREEN, 4, 1);
        countDown("pedYellow", ST_YELLOW, 3, 1);

        // Request during RED is held and applied on the first GREEN cycle.
        countDown("holdRedStart", ST_RED, 15, 15);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("holdReq", ST_RED, 4'd1, 4'd4, 1'b0);
        countDown("holdRed", ST_RED, 13, 1);
        countDown("holdGreen10", ST_GREEN, 10, 10);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("holdTrunc", ST_GREEN, 4'd0, 4'd5, 1'b1);
        countDown("holdAfter", ST_GREEN, 4, 1);
        countDown("holdYellow", ST_YELLOW, 3, 1);
        countDown("dropRed", ST_RED, 15, 1);

        // Requests at GREEN 4 and at GREEN 1 are dropped: no ack, no latch.
        countDown("dropGreen", ST_GREEN, 10, 4);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("drop4", ST_GREEN, 4'd0, 4'd3, 1'b0);
        countDown("dropMid", ST_GREEN, 2, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("drop1", ST_YELLOW, 4'd0, 4'd3, 1'b0);
        countDown("dropYellow", ST_YELLOW, 2, 1);
        countDown("dropRed2", ST_RED, 15, 1);
        countDown("dropNoLatch", ST_GREEN, 10, 9);

        // Reset mid-YELLOW together with a request: nothing carries over.
        countDown("rstGreen", ST_GREEN, 8, 1);
        countDown("rstYellow", ST_YELLOW, 3, 2);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("rstMid", ST_RED, 4'd1, 4'd5, 1'b0);
        countDown("rstRed", ST_RED, 14, 1);
        countDown("rstNoPend", ST_GREEN, 10, 9);

`ifdef NIGHT_MODE_EN
        // Night blink from mid-GREEN: YELLOW, NONE, YELLOW, NONE, then RED 15.
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("blink1", ST_YELLOW, 4'd0, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("blink2", ST_NONE, 4'd0, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("blink3", ST_YELLOW, 4'd0, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("blink4", ST_NONE, 4'd0, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("blinkExit", ST_RED, 4'd1, 4'd5, 1'b0);
        countDown("blinkRed", ST_RED, 14, 1);
        countDown("blinkNoPend", ST_GREEN, 10, 9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/traffic_light_controller.md
# traffic_light_controller

Phase sequencer for the red/green light design. Cycles the light through GREEN, YELLOW and RED with per-phase durations, and counts down the seconds remaining in the current phase. Drives the 2-bit `state` consumed by the dot-matrix display stage and a BCD countdown for the seven-segment stage. Also handles pedestrian requests, which shorten GREEN, and an optional night blink mode.

## Interface
- `GREEN_TIME`, default 10: GREEN phase length in ticks; legal range 1..99.
- `YELLOW_TIME`, default 3: YELLOW phase length in ticks; legal range 1..99.
- `RED_TIME`, default 15: RED phase length in ticks; legal range 1..99.
- `PED_MIN_GREEN`, default 5: GREEN remaining-time cap applied on a pedestrian request; legal range 1..GREEN_TIME.

Ports:
- `clk_div_1hz`, input, 1 bit: the only clock; one tick equals one second.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `ped_req`, input, 1 bit: pedestrian button, level-sampled each edge.
- `night_mode`, input, 1 bit: night blink request; used only with `NIGHT_MODE_EN`.
- `state`, output, 2 bits: light encoding RED=2'b00, YELLOW=2'b01, GREEN=2'b10, NONE=2'b11.
- `count_tens`, output, 4 bits: BCD tens digit of the remaining ticks.
- `count_ones`, output, 4 bits: BCD ones digit of the remaining ticks.
- `ped_ack`, output, 1 bit: one-cycle pulse when a pedestrian request shortens GREEN.

## Operation
- Internal registers:
  - FSM phase: GREEN, YELLOW, RED, plus BLINK when `NIGHT_MODE_EN` is defined.
  - `remaining`, 7 bits.
  - `ped_pending` flag.
  - `blink_phase` bit.
- Phase order: GREEN → YELLOW → RED → GREEN.
  - On entering a phase, `remaining` loads that phase's TIME.
  - In a normal cycle with `remaining` > 1, `remaining` decrements by 1.
  - When `remaining` == 1, the next edge moves to the next phase and reloads.
  - Each phase therefore lasts exactly TIME ticks, and the displayed count runs TIME, TIME-1, …, 1.
- Pedestrian request in GREEN (`ped_req` high or `ped_pending` set):
  - If `remaining` > `PED_MIN_GREEN`: `remaining` loads `PED_MIN_GREEN` instead of decrementing, `ped_ack` pulses for that cycle, and `ped_pending` clears.
  - If `remaining` <= `PED_MIN_GREEN`: the request is dropped, with no ack and no latch.
- Pedestrian request in YELLOW or RED (`ped_req` high): sets `ped_pending`. It is applied on the first GREEN cycle, where `remaining` = `GREEN_TIME`; that GREEN then lasts `PED_MIN_GREEN` + 1 ticks.
- `state` reflects the FSM phase. `count_tens`/`count_ones` are the BCD split of `remaining`; the conversion is done combinationally from the next `remaining` value and registered.
- Reset (takes effect at any point, mid-phase included):
  - FSM = RED, `remaining` = `RED_TIME`.
  - `state` = 2'b00, `count_tens`/`count_ones` = 1/5 with defaults.
  - `ped_ack` = 0, `ped_pending` = 0, `blink_phase` = 0.

## Timing
- All outputs are registered and update on the rising `clk_div_1hz` edge. There is no combinational input-to-output path.
- `ped_req` → `ped_ack`/count change: 1 cycle latency.
- A phase transition and its count reload occur on the same edge; `state` and the count never disagree.
- Simultaneous events:
  - `rst` beats everything.
  - Phase-end (`remaining` == 1) beats a pedestrian truncation.
  - Night entry beats a pedestrian request and clears `ped_pending`.
- `ped_ack` is never high for two consecutive cycles.

## Configuration
- `NIGHT_MODE_EN` defined:
  - `night_mode` high at any edge → BLINK on the next edge.
  - In BLINK, `state` alternates YELLOW, NONE, YELLOW, … starting with YELLOW, the count shows 0/0, and `ped_req` is ignored.
  - `night_mode` low while in BLINK → RED with `remaining` = `RED_TIME` on the next edge.
- `NIGHT_MODE_EN` undefined: `night_mode` is ignored, no BLINK state is built, and `state` never equals NONE.

## Test plan
- Reset, then run 28 ticks with defaults → RED for 15 ticks (counts 15..1), GREEN for 10 (10..1), YELLOW for 3 (3..1), then RED 15.
- `ped_req` pulse at GREEN `remaining` = 9 → next cycle count 5, `ped_ack` = 1 for one cycle; YELLOW 5 ticks later.
- `ped_req` pulse during RED → first GREEN shows 10, then 5, ack pulses once; GREEN lasts 6 ticks total.
- `ped_req` at GREEN `remaining` = 4, and separately at `remaining` = 1 → no ack, normal countdown, transition on time.
- With `NIGHT_MODE_EN`, raise `night_mode` mid-GREEN for 4 ticks → `state` YELLOW, NONE, YELLOW, NONE, count 0/0; on release → RED with 1/5.
- `rst` asserted mid-YELLOW together with `ped_req` → next edge `state` = 00, count 1/5, `ped_ack` = 0, no pending carried into the next GREEN.
